tl_cntr: RTL and testbench
==========================

# tl_cntr

Two-road traffic light controller: a Moore state machine with a dwell counter that sequences main road A and side road B through green, yellow and red based on car sensors. It sits downstream of the storage-element library: its state and counter registers are the consumers of our latch/flip-flop primitives. It drives the lamp-decoder outputs directly.

## Interface
- MIN_GREEN, 4: minimum green dwell in cycles for either road; legal range 1..255
- YELLOW_CYC, 3: exact yellow dwell in cycles; legal range 1..255
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset; one clock, synchronous reset
- ta  input  1  road A car sensor; 1 = traffic present
- tb  input  1  road B car sensor; 1 = traffic present
- la  output  2  road A lamp: 2'b00 green, 2'b01 yellow, 2'b10 red (2'b11 never driven)
- lb  output  2  road B lamp, same encoding
- state  output  2  current state code, for debug and the bench

## Operation
- States, 2-bit binary:
  - S0 = 2'b00: la green, lb red
  - S1 = 2'b01: la yellow, lb red
  - S2 = 2'b10: la red, lb green
  - S3 = 2'b11: la red, lb yellow
- Dwell counter cnt, 8 bits:
  - Cleared to 0 on every state transition.
  - Otherwise increments by 1 per cycle.
  - Saturates at 255; no wrap.
- Transitions, evaluated on each rising edge when reset = 0:
  - S0 -> S1 when ta == 0 and cnt >= MIN_GREEN-1; else stay in S0.
  - S1 -> S2 when cnt == YELLOW_CYC-1; ta and tb are ignored.
  - S2 -> S0 is not allowed. S2 -> S3 when tb == 0 and cnt >= MIN_GREEN-1; else stay in S2.
  - S3 -> S0 when cnt == YELLOW_CYC-1; sensors are ignored.
- Order is always S0 -> S1 -> S2 -> S3 -> S0. No other transitions exist.
- Both roads are never green or yellow at the same time. At least one of la/lb is red in every cycle.
- Sensor inputs are sampled only at the clock edge. Glitches between edges have no effect.
- Outputs la, lb and state are pure decodes of the state register (Moore). They never depend combinationally on ta or tb.

## Timing
- Reset (reset = 1 at a rising edge), on that edge:
  - state = S0, cnt = 0, la = 2'b00, lb = 2'b10.
  - This applies from any state and at any cnt, including mid-yellow.
  - reset has priority over every transition.
- Reset held for multiple cycles: remain in S0 with cnt = 0.
- Latency: a sensor change sampled at edge k is reflected on la/lb right after edge k, but only if the dwell condition is met at edge k.
- Yellow dwell: exactly YELLOW_CYC cycles.
- Green dwell:
  - At least MIN_GREEN cycles.
  - Unbounded while that road's own sensor stays 1.
  - The other road's sensor does not shorten green.
- Boundary conditions:
  - ta drops while cnt < MIN_GREEN-1 in S0: remain in S0 until cnt reaches MIN_GREEN-1, then leave at the first edge where ta == 0.
  - ta returns to 1 before that edge: stay in S0.
  - MIN_GREEN = 1 or YELLOW_CYC = 1: transition on the first edge in the state once the condition holds; dwell is 1 cycle.
  - cnt saturates at 255 during long green. The transition condition remains true, so exit happens immediately once the sensor drops.
- With ta = tb = 0 and default parameters, the full cycle period is 2*(MIN_GREEN+YELLOW_CYC) = 14 cycles.

## Test plan
- Reset then hold: reset for 2 edges with ta = 1, tb = 0, then hold for 50 cycles -> state = 2'b00, la = 2'b00, lb = 2'b10 throughout.
- Free-run, defaults, ta = tb = 0 from reset release (edge R):
  - S1 entered at edge R+4.
  - S2 at R+7, S3 at R+11, S0 at R+14.
  - Pattern repeats every 14 cycles.
  - la/lb match the state table each cycle.
- Minimum green: ta = 1 until after edge R+1, then 0 -> S1 still entered at R+4, not earlier. Second case: ta = 0 only at edge R+6 -> S1 entered at R+6.
- Side-road hold: reach S2, then keep tb = 1 for 20 cycles -> remain in S2 with lb = 2'b00 and la = 2'b10. Drop tb -> S3 on the next edge, then S0 exactly 3 cycles later.
- Reset mid-yellow: assert reset at the second cycle of S3 -> S0 with la = 2'b00, lb = 2'b10 on that edge. Subsequent dwell counts from 0.
- Safety assertion across 10,000 random ta/tb cycles, with random reset pulses:
  - Never la != 2'b10 and lb != 2'b10 at the same time.
  - Never la or lb = 2'b11.
  - Every yellow lasts exactly YELLOW_CYC cycles.
  - Run with MIN_GREEN/YELLOW_CYC set to 1/1, 4/3 and 255/255.

Source files
------------

// File: rtl/tl_cntr.sv
// tl_cntr: two-road Moore traffic light controller with saturating dwell counter
module tl_cntr #(
    parameter int MIN_GREEN  = 4,
    parameter int YELLOW_CYC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ta,
    input  logic       tb,
    output logic [1:0] la,
    output logic [1:0] lb,
    output logic [1:0] state
);
    typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} st_t;
    localparam logic [7:0] G_LAST = 8'(MIN_GREEN - 1);
    localparam logic [7:0] Y_LAST = 8'(YELLOW_CYC - 1);
    st_t cur, nxt;
    logic [7:0] cnt;
    assign state = cur;
    // next state: greens wait for the dwell minimum and a quiet own sensor, yellows for the exact dwell
    always_comb begin
        nxt = (cur == S0) ? ((!ta && cnt >= G_LAST) ? S1 : S0) :
              (cur == S1) ? ((cnt == Y_LAST) ? S2 : S1) :
              (cur == S2) ? ((!tb && cnt >= G_LAST) ? S3 : S2) :
                            ((cnt == Y_LAST) ? S0 : S3);
    end
    // state, dwell counter and lamps registered together so lamps are pure decodes of the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= S0;
            cnt <= 8'd0;
            la  <= 2'b00;
            lb  <= 2'b10;
        end else begin
            cur <= nxt;
            cnt <= (nxt != cur) ? 8'd0 : (cnt == 8'hff) ? cnt : cnt + 8'd1;
            la  <= (nxt == S0) ? 2'b00 : (nxt == S1) ? 2'b01 : 2'b10;
            lb  <= (nxt == S2) ? 2'b00 : (nxt == S3) ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: tb/tb_tl_cntr.sv
// tb_tl_cntr: directed and random self-checking bench for tl_cntr at 1/1, 4/3 and 255/255
module tb_tl_cntr;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ta = 1'b1;
    logic tb = 1'b0;
    logic [1:0] la_a, lb_a, st_a;
    logic [1:0] la_d, lb_d, st_d;
    logic [1:0] la_z, lb_z, st_z;
    int total = 0;
    int bad = 0;
    int ylen [3] = '{0, 0, 0};
    int ylim [3] = '{1, 3, 255};
    logic [1:0] la_tab [4] = '{2'b00, 2'b01, 2'b10, 2'b10};
    logic [1:0] lb_tab [4] = '{2'b10, 2'b10, 2'b00, 2'b01};

    tl_cntr #(.MIN_GREEN(1), .YELLOW_CYC(1)) u_a (
        .clk(clk), .reset(reset), .ta(ta), .tb(tb), .la(la_a), .lb(lb_a), .state(st_a));
    tl_cntr #(.MIN_GREEN(4), .YELLOW_CYC(3)) u_d (
        .clk(clk), .reset(reset), .ta(ta), .tb(tb), .la(la_d), .lb(lb_d), .state(st_d));
    tl_cntr #(.MIN_GREEN(255), .YELLOW_CYC(255)) u_z (
        .clk(clk), .reset(reset), .ta(ta), .tb(tb), .la(la_z), .lb(lb_z), .state(st_z));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic expect_d(input string tag, input logic [1:0] st);
        chk({tag, ".state"}, 32'(st_d), 32'(st));
        chk({tag, ".la"}, 32'(la_d), 32'(la_tab[st]));
        chk({tag, ".lb"}, 32'(lb_d), 32'(lb_tab[st]));
    endtask

    task automatic safe(input int i, input logic [1:0] l_a, input logic [1:0] l_b,
                        input logic [1:0] st, input logic rs);
        chk("safe.one_red", 32'(l_a == 2'b10 || l_b == 2'b10), 32'd1);
        chk("safe.la_legal", 32'(l_a != 2'b11), 32'd1);
        chk("safe.lb_legal", 32'(l_b != 2'b11), 32'd1);
        if (rs) begin
            chk("safe.reset_state", 32'(st), 32'd0);
            ylen[i] = 0;
        end else if (l_a == 2'b01 || l_b == 2'b01) begin
            ylen[i]++;
            if (ylen[i] > ylim[i]) chk("safe.yellow_long", 32'(ylen[i]), 32'(ylim[i]));
        end else if (ylen[i] > 0) begin
            chk("safe.yellow_len", 32'(ylen[i]), 32'(ylim[i]));
            ylen[i] = 0;
        end
    endtask

    initial begin
        logic rs;
        // reset for two edges, then hold S0 with ta=1 long enough to saturate cnt
        ta = 1'b1;
        tb = 1'b0;
        reset = 1'b1;
        step();
        step();
        expect_d("reset", 2'b00);
        reset = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            step();
            if (k <= 50 || k == 256) expect_d("hold", 2'b00);
        end
        ta = 1'b0;
        step();
        expect_d("sat_exit", 2'b01);

        // free run with both sensors quiet: 14-cycle period on defaults, 4 on 1/1
        ta = 1'b0;
        tb = 1'b0;
        do_reset();
        for (int k = 1; k <= 28; k++) begin
            int p;
            step();
            p = k % 14;
            expect_d("free", (p < 4) ? 2'b00 : (p < 7) ? 2'b01 : (p < 11) ? 2'b10 : 2'b11);
            chk("free_min1.state", 32'(st_a), 32'(k % 4));
        end

        // minimum green: ta drops after edge R+1, S1 still only at R+4
        ta = 1'b1;
        do_reset();
        step();
        ta = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            step();
            expect_d("min_green", (k >= 4) ? 2'b01 : 2'b00);
        end

        // ta low only at edge R+6: S1 at R+6, S2 three edges later
        ta = 1'b1;
        do_reset();
        for (int k = 1; k <= 5; k++) step();
        expect_d("late_drop.pre", 2'b00);
        ta = 1'b0;
        step();
        ta = 1'b1;
        expect_d("late_drop.r6", 2'b01);
        step();
        step();
        expect_d("late_drop.yel", 2'b01);
        step();
        expect_d("late_drop.s2", 2'b10);

        // side road holds green while tb=1, then exact yellow dwell
        tb = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            expect_d("side_hold", 2'b10);
        end
        tb = 1'b0;
        step();
        expect_d("side_s3", 2'b11);
        step();
        step();
        expect_d("side_s3_end", 2'b11);
        step();
        expect_d("side_s0", 2'b00);

        // reset in the second cycle of S3, then dwell restarts from zero
        ta = 1'b0;
        tb = 1'b0;
        do_reset();
        for (int k = 1; k <= 12; k++) step();
        expect_d("mid_yel.pre", 2'b11);
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_d("mid_yel.rst", 2'b00);
        for (int k = 1; k <= 4; k++) begin
            step();
            expect_d("mid_yel.after", (k == 4) ? 2'b01 : 2'b00);
        end

        // random sensors with sparse reset pulses on all three parameter sets
        ylen = '{0, 0, 0};
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            ta = 1'($urandom_range(0, 1));
            tb = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 1999) == 0);
            reset = rs;
            step();
            safe(0, la_a, lb_a, st_a, rs);
            safe(1, la_d, lb_d, st_d, rs);
            safe(2, la_z, lb_z, st_z, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
